// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS-lite fetch-stage constants, types and helpers
package mips_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [XLEN-1:0] EXC_VEC_DEF  = 32'h0000_0080;
  localparam logic [XLEN-1:0] INST_BYTES   = 32'd4;

  // Next-PC source, listed from highest to lowest priority
  typedef enum logic [3:0] {
    NPC_RST,
    NPC_EXC,
    NPC_EPC,
    NPC_HOLD,
    NPC_PEND,
    NPC_JR,
    NPC_J,
    NPC_B,
    NPC_SEQ
  } npc_sel_e;

  // Word offset of a branch, sign-extended and scaled to bytes
  function automatic logic [XLEN-1:0] br_offset(input logic [15:0] imm);
    return {{(XLEN-18){imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/pc_ctrl_if.sv
// rtl/pc_ctrl_if.sv - redirect request / fetch address bundle for pc_ctrl
interface pc_ctrl_if;
  import mips_pkg::*;

  logic            stall;
  logic            branch;
  logic            jmp;
  logic            jr;
  logic [15:0]     imm16;
  logic [25:0]     imm26;
  logic [XLEN-1:0] rs_val;
  logic            exc;
  logic            eret;
  logic [XLEN-1:0] epc;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] npc;
  logic [XLEN-1:0] link_addr;
  logic            in_slot;
  logic            addr_err;

  modport master (
    output stall, branch, jmp, jr, imm16, imm26, rs_val, exc, eret, epc,
    input  pc, npc, link_addr, in_slot, addr_err
  );

  modport slave (
    input  stall, branch, jmp, jr, imm16, imm26, rs_val, exc, eret, epc,
    output pc, npc, link_addr, in_slot, addr_err
  );

endinterface

// File: rtl/pc_target_calc.sv
// rtl/pc_target_calc.sv - combinational sequential/branch/jump/link targets
module pc_target_calc
  import mips_pkg::*;
#(
  parameter bit DELAY_SLOT = 1'b0
) (
  input  logic [XLEN-1:0] pc,
  input  logic [15:0]     imm16,
  input  logic [25:0]     imm26,
  output logic [XLEN-1:0] pc4,
  output logic [XLEN-1:0] pc_b,
  output logic [XLEN-1:0] pc_j,
  output logic [XLEN-1:0] link_addr
);

  assign pc4  = pc + INST_BYTES;
  assign pc_b = pc4 + br_offset(imm16);
  // Jump region comes from the instruction after the jump, not the jump itself
  assign pc_j = {pc4[XLEN-1:28], imm26, 2'b00};
  // With a delay slot the return skips over the slot instruction
  assign link_addr = DELAY_SLOT ? (pc + (INST_BYTES << 1)) : pc4;

endmodule

// File: rtl/pc_ctrl.sv
// rtl/pc_ctrl.sv - fetch-stage PC register, next-PC priority mux and delay slot
module pc_ctrl
  import mips_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEF,
  parameter logic [XLEN-1:0] EXC_VEC    = EXC_VEC_DEF,
  parameter bit              DELAY_SLOT = 1'b0
) (
  input logic        clk,
  input logic        rst,
  pc_ctrl_if.slave   bus
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SLOT = 1'b1;

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pend_tgt_q;
  logic [0:0]      state_q;
  logic            pend_vld;
  logic [XLEN-1:0] pc4, pc_b, pc_j, link_addr;
  logic [XLEN-1:0] xfer_tgt;
  logic [XLEN-1:0] npc;
  logic            taken;
  npc_sel_e        sel;

  pc_target_calc #(.DELAY_SLOT(DELAY_SLOT)) u_tgt (
    .pc        (pc_q),
    .imm16     (bus.imm16),
    .imm26     (bus.imm26),
    .pc4       (pc4),
    .pc_b      (pc_b),
    .pc_j      (pc_j),
    .link_addr (link_addr)
  );

  assign pend_vld = DELAY_SLOT && (state_q == SLOT);
  assign taken    = bus.jr || bus.jmp || bus.branch;
  assign xfer_tgt = bus.jr ? bus.rs_val : (bus.jmp ? pc_j : pc_b);

  // Pick the next-PC source; with a delay slot a fresh transfer is deferred
  always_comb begin
    sel = NPC_SEQ;
    if (rst)              sel = NPC_RST;
    else if (bus.exc)     sel = NPC_EXC;
    else if (bus.eret)    sel = NPC_EPC;
    else if (bus.stall)   sel = NPC_HOLD;
    else if (pend_vld)    sel = NPC_PEND;
    else if (DELAY_SLOT)  sel = NPC_SEQ;
    else if (bus.jr)      sel = NPC_JR;
    else if (bus.jmp)     sel = NPC_J;
    else if (bus.branch)  sel = NPC_B;
  end

  // Next-PC data mux driven by the selected source
  always_comb begin
    npc = pc4;
    case (sel)
      NPC_RST:  npc = RESET_PC;
      NPC_EXC:  npc = EXC_VEC;
      NPC_EPC:  npc = bus.epc;
      NPC_HOLD: npc = pc_q;
      NPC_PEND: npc = pend_tgt_q;
      NPC_JR:   npc = bus.rs_val;
      NPC_J:    npc = pc_j;
      NPC_B:    npc = pc_b;
      default:  npc = pc4;
    endcase
  end

  // PC register always takes the mux output; reset is one of the mux sources
  always_ff @(posedge clk) begin
    if (rst) pc_q <= RESET_PC;
    else     pc_q <= npc;
  end

  // Delay-slot FSM: capture a taken target in IDLE, release it after the slot
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pend_tgt_q <= '0;
    end else if (bus.exc || bus.eret) begin
      state_q <= IDLE;
    end else if (!bus.stall) begin
      if (state_q == SLOT) begin
        state_q <= IDLE;
      end else if (DELAY_SLOT && taken) begin
        state_q    <= SLOT;
        pend_tgt_q <= xfer_tgt;
      end
    end
  end

  assign bus.pc        = pc_q;
  assign bus.npc       = npc;
  assign bus.link_addr = link_addr;
  assign bus.in_slot   = pend_vld;
  assign bus.addr_err  = |npc[1:0];

endmodule

// File: tb/tb_pc_ctrl.sv
// tb/tb_pc_ctrl.sv - scoreboard bench for pc_ctrl with and without delay slot
module tb_pc_ctrl;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] EXC_PC = 32'h0000_0080;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] npc;
    logic [31:0] link;
    logic        slot;
    logic        aerr;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic d_stall, d_branch, d_jmp, d_jr, d_exc, d_eret;
  logic [15:0] d_imm16;
  logic [25:0] d_imm26;
  logic [31:0] d_rs, d_epc;

  int checks = 0;
  int failures = 0;

  exp_t q0[$];
  exp_t q1[$];

  logic [31:0] m_pc[2];
  bit          m_pv[2];
  logic [31:0] m_pt[2];

  always #5 clk = ~clk;

  pc_ctrl_if i0 ();
  pc_ctrl_if i1 ();

  assign i0.stall = d_stall;   assign i1.stall = d_stall;
  assign i0.branch = d_branch; assign i1.branch = d_branch;
  assign i0.jmp = d_jmp;       assign i1.jmp = d_jmp;
  assign i0.jr = d_jr;         assign i1.jr = d_jr;
  assign i0.imm16 = d_imm16;   assign i1.imm16 = d_imm16;
  assign i0.imm26 = d_imm26;   assign i1.imm26 = d_imm26;
  assign i0.rs_val = d_rs;     assign i1.rs_val = d_rs;
  assign i0.exc = d_exc;       assign i1.exc = d_exc;
  assign i0.eret = d_eret;     assign i1.eret = d_eret;
  assign i0.epc = d_epc;       assign i1.epc = d_epc;

  pc_ctrl #(.RESET_PC(RST_PC), .EXC_VEC(EXC_PC), .DELAY_SLOT(1'b0)) u0 (
    .clk(clk), .rst(rst), .bus(i0));
  pc_ctrl #(.RESET_PC(RST_PC), .EXC_VEC(EXC_PC), .DELAY_SLOT(1'b1)) u1 (
    .clk(clk), .rst(rst), .bus(i1));

  // Reference: next PC straight from the priority rules, with the delay slot
  // modelled as "remember the target, go to pc+4, then jump to it".
  function automatic void model(input bit ds, input logic [31:0] pc, input bit pv,
                                input logic [31:0] pt, output logic [31:0] nx,
                                output bit npv, output logic [31:0] npt);
    logic [31:0] p4;
    logic [31:0] tgt;
    p4  = pc + 32'd4;
    npv = pv;
    npt = pt;
    if (d_jr)       tgt = d_rs;
    else if (d_jmp) tgt = {p4[31:28], d_imm26, 2'b00};
    else            tgt = p4 + {{14{d_imm16[15]}}, d_imm16, 2'b00};
    if (rst)                 begin nx = RST_PC; npv = 1'b0; npt = 32'h0; end
    else if (d_exc)          begin nx = EXC_PC; npv = 1'b0; end
    else if (d_eret)         begin nx = d_epc;  npv = 1'b0; end
    else if (d_stall)        nx = pc;
    else if (pv)             begin nx = pt; npv = 1'b0; end
    else if (d_jr || d_jmp || d_branch) begin
      if (ds) begin nx = p4; npv = 1'b1; npt = tgt; end
      else    nx = tgt;
    end
    else nx = p4;
  endfunction

  task automatic step(input bit r, input bit s, input bit b, input bit j, input bit jrr,
                      input logic [15:0] i16, input logic [25:0] i26, input logic [31:0] rs,
                      input bit e, input bit er, input logic [31:0] ep);
    exp_t x;
    logic [31:0] nx;
    logic [31:0] npt;
    bit npv;
    rst = r; d_stall = s; d_branch = b; d_jmp = j; d_jr = jrr;
    d_imm16 = i16; d_imm26 = i26; d_rs = rs; d_exc = e; d_eret = er; d_epc = ep;
    for (int d = 0; d < 2; d++) begin
      model(d == 1, m_pc[d], m_pv[d], m_pt[d], nx, npv, npt);
      x.pc   = m_pc[d];
      x.npc  = nx;
      x.link = m_pc[d] + ((d == 1) ? 32'd8 : 32'd4);
      x.slot = m_pv[d];
      x.aerr = (nx[1:0] != 2'b00);
      if (d == 0) q0.push_back(x);
      else        q1.push_back(x);
      m_pc[d] = nx;
      m_pv[d] = npv;
      m_pt[d] = npt;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 16'h0, 26'h0, 32'h0, 0, 0, 32'h0);
  endtask

  // Bring both DUTs to the same PC via exception entry and return
  task automatic go(input logic [31:0] a);
    step(0, 0, 0, 0, 0, 16'h0, 26'h0, 32'h0, 1, 0, 32'h0);
    step(0, 0, 0, 0, 0, 16'h0, 26'h0, 32'h0, 0, 1, a);
  endtask

  task automatic cmp(input string nm, input int d, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s ds%0d actual=%h required=%h", nm, d, act, req);
    end
  endtask

  // Monitor: every cycle both DUTs present outputs; pop and compare
  always @(negedge clk) begin
    exp_t x;
    if (q0.size() > 0) begin
      x = q0.pop_front();
      cmp("pc", 0, i0.pc, x.pc);
      cmp("npc", 0, i0.npc, x.npc);
      cmp("link_addr", 0, i0.link_addr, x.link);
      cmp("in_slot", 0, {31'h0, i0.in_slot}, {31'h0, x.slot});
      cmp("addr_err", 0, {31'h0, i0.addr_err}, {31'h0, x.aerr});
    end
    if (q1.size() > 0) begin
      x = q1.pop_front();
      cmp("pc", 1, i1.pc, x.pc);
      cmp("npc", 1, i1.npc, x.npc);
      cmp("link_addr", 1, i1.link_addr, x.link);
      cmp("in_slot", 1, {31'h0, i1.in_slot}, {31'h0, x.slot});
      cmp("addr_err", 1, {31'h0, i1.addr_err}, {31'h0, x.aerr});
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit r, s, b, j, jrr, e, er;
    logic [31:0] rs;
    int waited;
    rst = 1'b1; d_stall = 0; d_branch = 0; d_jmp = 0; d_jr = 0; d_exc = 0; d_eret = 0;
    d_imm16 = '0; d_imm26 = '0; d_rs = '0; d_epc = '0;
    for (int d = 0; d < 2; d++) begin m_pc[d] = RST_PC; m_pv[d] = 0; m_pt[d] = 0; end
    @(posedge clk);
    #1;
    step(1, 0, 0, 0, 0, 16'h0, 26'h0, 32'h0, 0, 0, 32'h0);
    idle(4);
    go(32'h100);
    step(0, 0, 1, 0, 0, 16'hFFFF, 26'h0, 32'h0, 0, 0, 32'h0);
    idle(2);
    go(32'hFFFF_FFFC);
    step(0, 0, 0, 1, 0, 16'h0, 26'h40, 32'h0, 0, 0, 32'h0);
    idle(2);
    go(32'h200);
    step(0, 0, 0, 1, 0, 16'h0, 26'h100, 32'h0, 0, 0, 32'h0);
    step(0, 0, 1, 0, 0, 16'h0040, 26'h0, 32'h0, 0, 0, 32'h0);
    idle(2);
    go(32'h200);
    step(0, 0, 0, 1, 0, 16'h0, 26'h100, 32'h0, 0, 0, 32'h0);
    repeat (3) step(0, 1, 0, 0, 0, 16'h0, 26'h0, 32'h0, 0, 0, 32'h0);
    idle(2);
    go(32'h300);
    step(0, 1, 0, 0, 1, 16'h0, 26'h0, 32'h500, 0, 0, 32'h0);
    idle(1);
    go(32'h200);
    step(0, 0, 0, 1, 0, 16'h0, 26'h100, 32'h0, 0, 0, 32'h0);
    step(0, 1, 0, 0, 0, 16'h0, 26'h0, 32'h0, 1, 0, 32'h0);
    idle(2);
    step(0, 0, 0, 0, 0, 16'h0, 26'h0, 32'h0, 0, 1, 32'h1234);
    step(0, 0, 0, 0, 0, 16'h0, 26'h0, 32'h0, 1, 1, 32'h1234);
    step(0, 0, 0, 0, 1, 16'h0, 26'h0, 32'h302, 0, 0, 32'h0);
    idle(2);
    go(32'h200);
    step(0, 0, 0, 1, 0, 16'h0, 26'h100, 32'h0, 0, 0, 32'h0);
    step(1, 0, 0, 0, 0, 16'h0, 26'h0, 32'h0, 0, 0, 32'h0);
    idle(2);
    for (int n = 0; n < 600; n++) begin
      r   = ($urandom_range(0, 63) == 0);
      s   = ($urandom_range(0, 3) == 0);
      b   = ($urandom_range(0, 2) == 0);
      j   = ($urandom_range(0, 3) == 0);
      jrr = ($urandom_range(0, 3) == 0);
      e   = ($urandom_range(0, 31) == 0);
      er  = ($urandom_range(0, 31) == 0);
      rs  = ($urandom_range(0, 7) == 0) ? 32'($urandom) : (32'($urandom) & 32'hFFFF_FFFC);
      step(r, s, b, j, jrr, 16'($urandom), 26'($urandom), rs, e, er,
           32'($urandom) & 32'hFFFF_FFFC);
    end
    waited = 0;
    while ((q0.size() > 0 || q1.size() > 0) && waited < 20) begin
      @(posedge clk);
      waited++;
    end
    checks++;
    if (q0.size() > 0 || q1.size() > 0) begin
      failures++;
      $display("FAIL drain actual=%0d required=0", q0.size() + q1.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_ctrl.md
# pc_ctrl

Parametrised program-counter controller for the MIPS-lite fetch stage: owns the PC register and computes the next PC from sequential, branch, jump, register-jump, exception and exception-return sources. It adds stall hold, an optional architectural branch delay slot with a pending-target register, and a link-address output for `jal`/`jalr`. It sits between the decoder/ALU (redirect requests) and instruction memory (`pc` drives the fetch address).

## Interface

**Parameters**
- `RESET_PC`, default `32'h0000_0000`: PC value loaded on reset.
- `EXC_VEC`, default `32'h0000_0080`: exception entry address.
- `DELAY_SLOT`, default `0`: `1` means a taken transfer executes the following instruction before the target.

**Ports** (clock and reset first)
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `stall` in 1: hold the PC and pending state this cycle.
- `branch` in 1: conditional branch at `pc` resolved taken.
- `jmp` in 1: `j`/`jal` at `pc`.
- `jr` in 1: `jr`/`jalr` at `pc`.
- `imm16` in 16: branch offset in words.
- `imm26` in 26: jump index.
- `rs_val` in 32: register target for `jr`.
- `exc` in 1: take an exception this cycle.
- `eret` in 1: return from exception.
- `epc` in 32: return address for `eret`.
- `pc` out 32: current fetch address (registered).
- `npc` out 32: value `pc` takes at the next edge (combinational).
- `link_addr` out 32: `pc+8` if `DELAY_SLOT`, else `pc+4`.
- `in_slot` out 1: the instruction at `pc` is a delay-slot instruction.
- `addr_err` out 1: the selected next PC has `[1:0] != 0` (combinational).

## Operation

**Targets** (all arithmetic is 32-bit modulo 2^32)
- `pc4 = pc + 4`
- `pc_b = pc4 + {sext(imm16), 2'b00}`
- `pc_j = {pc4[31:28], imm26, 2'b00}`
- `pc_r = rs_val`, used unaligned as given.

**Next-PC selection**, highest priority first:
1. `rst` → `RESET_PC`
2. `exc` → `EXC_VEC`
3. `eret` → `epc`
4. `stall` → `pc` (hold)
5. pending target valid (`DELAY_SLOT=1` only) → `pend_tgt`
6. `jr` → `pc_r`
7. `jmp` → `pc_j`
8. `branch` → `pc_b`
9. otherwise → `pc4`

**Delay-slot state** (`DELAY_SLOT=1`): a two-state FSM over `pend_vld`.
- `IDLE`: a taken transfer (rules 6–8) does not redirect. `npc = pc4`, `pend_tgt` captures the selected target, and the FSM moves to `SLOT`.
- `SLOT`: `in_slot=1`. The next unstalled edge loads `pc <= pend_tgt` and returns to `IDLE`. `branch`/`jmp`/`jr` asserted in the slot are ignored, since the pending target wins.
- `stall` in either state: `pc`, `pend_tgt` and `pend_vld` all hold.
- `exc` or `eret`: clears `pend_vld` and the FSM returns to `IDLE`. `in_slot` is sampled by CP0 for EPC/BD.
- With `DELAY_SLOT=0`, `pend_vld` is tied to 0 and `in_slot` is tied to 0.

**Other rules**
- Simultaneous `branch`/`jmp`/`jr` resolve by the fixed priority above; there is no error flag.
- `addr_err` reflects `npc[1:0] != 0` in every mode and does not alter `npc`.

## Timing
- **Reset values:** `pc = RESET_PC`, `pend_vld = 0`, `pend_tgt = 0`, `in_slot = 0`. In the reset cycle, `npc`, `link_addr` and `addr_err` follow from these values.
- **Latency:** a redirect issued in cycle N appears on `pc` in cycle N+1 (`DELAY_SLOT=0`), or in cycle N+2 after one unstalled slot cycle (`DELAY_SLOT=1`).
- `rst` in the middle of a pending slot discards the pending target.
- `exc` during `stall` is taken; `stall` does not mask it.

## Structure
- **Shared package `mips_pkg`:** `XLEN = 32`, default `RESET_PC`, default `EXC_VEC`, and `INST_BYTES = 4`.
- **Sub-module `pc_target_calc`:** purely combinational, computing `pc4`, `pc_b`, `pc_j` and `link_addr`, parametrised on `DELAY_SLOT`.
- **In `pc_ctrl`:** the priority mux and the PC and pending registers. Muxing may use the library `MuxKeyWithDefault`.

## Test plan
- **Reset:** hold `rst` for 2 cycles → `pc = 0x0000_0000`, `in_slot = 0`. Release with no requests → `pc` sequence `0x4`, `0x8`, `0xC`.
- **Branch:** `pc = 0x100`, `branch = 1`, `imm16 = 0xFFFF` → `npc = 0x100`. With `DELAY_SLOT=0`, `pc = 0x100` next cycle. Then `jmp`, `imm26 = 0x0000040`, at `pc = 0xFFFF_FFFC` → `pc = 0x0000_0100` (region taken from `pc4`).
- **Delay slot** (`DELAY_SLOT=1`):
  - `jmp` at `0x200` to `0x400` → `pc` sequence `0x204` (`in_slot = 1`), then `0x400`.
  - `branch` asserted at `0x204` is ignored.
  - `link_addr` at `0x200` = `0x208`.
- **Stall:**
  - During `SLOT`, 3 stall cycles → `pc` holds `0x204`, `in_slot` stays 1, then `pc = 0x400`.
  - `stall` together with `jr` → `pc` holds.
- **Exception/eret:**
  - `exc` together with `stall` and pending valid → `pc = 0x80`, pending cleared.
  - `eret` with `epc = 0x1234` → `pc = 0x1234`.
  - `exc` and `eret` together → `0x80`.
- **Register jump:**
  - `jr` with `rs_val = 0x0000_0302` → `addr_err = 1` in that cycle, `pc = 0x302` next.
  - `rst` asserted mid-slot → `pc = RESET_PC`, `pend_vld = 0`.
